// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default bit period.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  // Default clk cycles per serial bit, shared with the transmit side
  localparam int UART_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_rx_pin_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial pin; resets to the idle (high) level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_pin.sv
// 8-bit UART receiver (idle-high, LSB first) with mid-bit sampling, optional parity,
// framing/parity/overrun pulses and a one-entry valid/ready holding register.
module uart_rx_pin
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t   r_state;
  uart_state_t   w_state_next;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_par_err;
  logic          w_par_next;
  logic          w_good;
  logic          w_frame;
  logic          w_perr;
  logic          w_tick;
  logic          w_rx_s;

  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_parity_err;
  logic          r_overrun;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx_i),
    .o_q (w_rx_s)
  );

  assign w_tick = (r_bit_cnt == '0);

  // Frame state and bit-timing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_par_err <= w_par_next;
    end
  end

  // Next-state, bit sampling and end-of-frame decisions
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_bit_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_par_next   = r_par_err;
    w_good       = 1'b0;
    w_frame      = 1'b0;
    w_perr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = ST_START;
          w_cnt_next   = CNT_HALF;
        end
      end
      ST_START: begin
        if (!w_tick) begin
          w_cnt_next = r_bit_cnt - 1'b1;
        end else if (w_rx_s) begin
          // Start bit gone high by mid-bit: treat as a glitch
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DATA;
          w_cnt_next   = CNT_FULL;
          w_idx_next   = '0;
          w_par_next   = 1'b0;
        end
      end
      ST_DATA: begin
        if (!w_tick) begin
          w_cnt_next = r_bit_cnt - 1'b1;
        end else begin
          w_shift_next = {w_rx_s, r_shift[7:1]};
          w_cnt_next   = CNT_FULL;
          if (r_idx == 3'd7) begin
            w_state_next = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (!w_tick) begin
          w_cnt_next = r_bit_cnt - 1'b1;
        end else begin
          w_par_next   = (w_rx_s != ((^r_shift) ^ PARITY_ODD));
          w_cnt_next   = CNT_FULL;
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!w_tick) begin
          w_cnt_next = r_bit_cnt - 1'b1;
        end else if (!w_rx_s) begin
          // Framing error outranks any parity mismatch
          w_frame      = 1'b1;
          w_state_next = ST_WAIT_IDLE;
        end else if (r_par_err) begin
          w_perr       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_good       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Holding register, handshake and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_frame;
      r_parity_err <= w_perr;
      r_overrun    <= 1'b0;
      if (w_good) begin
        if (!r_valid || rx_ready_i) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data_o    = r_data;
  assign rx_valid_o   = r_valid;
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
